// File: rtl/store_buffer.sv
// Store buffer in front of the data cache.
// Accepts SB/SH/SW requests, rejects illegal or misaligned ones with a
// one-cycle store_err pulse, formats legal stores onto byte lanes with
// per-byte enables, and queues them in a small FIFO that drains word-aligned
// writes to the memory port. Pending entries that share a word with a probing
// load raise ld_conflict so the pipeline can stall that load.
//
// Handshakes: both ports use valid/ready. A beat transfers on a rising clk
// edge where valid && ready. st_ready depends only on FIFO occupancy (never on
// st_valid), and mem_valid/mem_* are held stable until mem_ready is seen.
module store_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [2:0]            st_addr_mode,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [3:0]            mem_be,
  input  logic                  ld_check_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  ld_conflict,
  output logic                  store_err,
  output logic                  full,
  output logic                  empty
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [2:0]      MODE_B   = 3'b000;
  localparam logic [2:0]      MODE_H   = 3'b001;
  localparam logic [2:0]      MODE_W   = 3'b010;

  // Pointer and occupancy state
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [PTR_W:0]        r_count;
  logic [DEPTH-1:0]      r_vld;
  logic                  r_store_err;

  // Entry payload storage
  logic [ADDR_WIDTH-1:0] r_addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
  logic [3:0]            r_be_mem   [DEPTH];

  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic                  w_legal_mode;
  logic                  w_aligned;
  logic                  w_legal;
  logic                  w_enq;
  logic                  w_deq;
  logic [DATA_WIDTH-1:0] w_lane_data;
  logic [3:0]            w_lane_be;
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic                  w_hit;
  logic                  w_unused_ld_lsb;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_accept  = st_valid && !w_full;
  assign w_legal   = w_legal_mode && w_aligned;
  assign w_enq     = w_accept && w_legal;
  assign w_deq     = !w_empty && mem_ready;
  assign w_word_addr = {st_addr[ADDR_WIDTH-1:2], 2'b00};

  // Load overlap is judged per word, so the byte offset of the load is ignored.
  assign w_unused_ld_lsb = ^ld_addr[1:0];

  // Decode the store size, check alignment and replicate data onto byte lanes
  always_comb begin
    w_legal_mode = 1'b0;
    w_aligned    = 1'b0;
    w_lane_data  = st_data;
    w_lane_be    = 4'b0000;
    case (st_addr_mode)
      MODE_B: begin
        w_legal_mode = 1'b1;
        w_aligned    = 1'b1;
        w_lane_data  = {4{st_data[7:0]}};
        w_lane_be    = 4'b0001 << st_addr[1:0];
      end
      MODE_H: begin
        w_legal_mode = 1'b1;
        w_aligned    = ~st_addr[0];
        w_lane_data  = {2{st_data[15:0]}};
        w_lane_be    = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      MODE_W: begin
        w_legal_mode = 1'b1;
        w_aligned    = (st_addr[1:0] == 2'b00);
        w_lane_data  = st_data;
        w_lane_be    = 4'b1111;
      end
      default: begin
        w_legal_mode = 1'b0;
      end
    endcase
  end

  // Pointers, occupancy, entry valid bits and the error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_vld       <= '0;
      r_store_err <= 1'b0;
    end else begin
      r_store_err <= w_accept && !w_legal;
      // enq and deq never target the same slot: enq needs !full, deq needs !empty
      if (w_deq) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PTR_W'(1);
      end
      if (w_enq) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload write on enqueue; contents of free slots are don't-care
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr_mem[r_tail] <= w_word_addr;
      r_data_mem[r_tail] <= w_lane_data;
      r_be_mem[r_tail]   <= w_lane_be;
    end
  end

  // Word-granular overlap search across all pending entries
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_addr_mem[i][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2])) begin
        w_hit = 1'b1;
      end
    end
  end

  assign ld_conflict = ld_check_en && w_hit;
  assign st_ready    = !w_full;
  assign full        = w_full;
  assign empty       = w_empty;
  assign store_err   = r_store_err;
  assign mem_valid   = !w_empty;
  // Head entry drives the port directly; zeros are forced while empty.
  assign mem_addr    = w_empty ? '0 : r_addr_mem[r_head];
  assign mem_data    = w_empty ? '0 : r_data_mem[r_head];
  assign mem_be      = w_empty ? '0 : r_be_mem[r_head];

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: scenario tasks with inline checks plus a
// negedge scoreboard monitor comparing every memory-port transfer against
// the expected queue filled when stores are driven.
module tb_store_buffer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int W     = AW + DW + 4;

  logic          clk;
  logic          rst_n;
  logic          st_valid;
  logic          st_ready;
  logic [2:0]    st_addr_mode;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [3:0]    mem_be;
  logic          ld_check_en;
  logic [AW-1:0] ld_addr;
  logic          ld_conflict;
  logic          store_err;
  logic          full;
  logic          empty;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mon_exp;

  store_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr_mode (st_addr_mode),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_be       (mem_be),
    .ld_check_en  (ld_check_en),
    .ld_addr      (ld_addr),
    .ld_conflict  (ld_conflict),
    .store_err    (store_err),
    .full         (full),
    .empty        (empty)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_legal(input logic [2:0] mode, input logic [AW-1:0] a);
    case (mode)
      3'b000:  return 1'b1;
      3'b001:  return (a[0] == 1'b0);
      3'b010:  return (a[1:0] == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [W-1:0] fmt(input logic [2:0] mode, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d);
    logic [DW-1:0] lanes;
    logic [3:0]    be;
    case (mode)
      3'b000: begin
        lanes = {d[7:0], d[7:0], d[7:0], d[7:0]};
        case (a[1:0])
          2'd0:    be = 4'b0001;
          2'd1:    be = 4'b0010;
          2'd2:    be = 4'b0100;
          default: be = 4'b1000;
        endcase
      end
      3'b001: begin
        lanes = {d[15:0], d[15:0]};
        be    = a[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lanes = d;
        be    = 4'b1111;
      end
    endcase
    return {a[AW-1:2], 2'b00, lanes, be};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && mem_valid && mem_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL mem_xfer_unexpected: got addr=%h data=%h be=%b, required no transfer",
                 mem_addr, mem_data, mem_be);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({mem_addr, mem_data, mem_be} !== mon_exp)
          $display("FAIL mem_xfer: got addr=%h data=%h be=%b, required addr=%h data=%h be=%b",
                   mem_addr, mem_data, mem_be, mon_exp[W-1 -: AW], mon_exp[DW+3:4], mon_exp[3:0]);
        else
          n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_store(input logic [2:0] mode, input logic [AW-1:0] a, input logic [DW-1:0] d);
    st_valid     = 1'b1;
    st_addr_mode = mode;
    st_addr      = a;
    st_data      = d;
    n_checks++;
    if (st_ready !== 1'b1) $display("FAIL st_ready_before_store: got %b, required 1", st_ready);
    else n_pass++;
    if (is_legal(mode, a)) exp_q.push_back(fmt(mode, a, d));
    tick();
    st_valid = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int k;
    k = 0;
    while (empty !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (empty !== 1'b1) $display("FAIL drain_timeout: got empty=%b after %0d cycles, required 1", empty, k);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL drain_leftover: got %0d expected entries pending, required 0", exp_q.size());
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    ld_check_en = 1'b1;
    ld_addr = '0;
    tick();
    tick();
    n_checks++;
    if ({mem_valid, empty, full, st_ready, store_err, ld_conflict} !== 6'b010100)
      $display("FAIL reset_flags: got mv/em/fu/sr/se/lc=%b, required 010100",
               {mem_valid, empty, full, st_ready, store_err, ld_conflict});
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_data, mem_be} !== '0)
      $display("FAIL reset_mem_bus: got addr=%h data=%h be=%b, required zeros", mem_addr, mem_data, mem_be);
    else n_pass++;
    rst_n = 1'b1;
    ld_check_en = 1'b0;
    tick();
  endtask

  task automatic test_byte_store();
    mem_ready = 1'b0;
    drive_store(3'b000, 32'h0000_1003, 32'h0000_00A5);
    n_checks++;
    if ({mem_valid, empty} !== 2'b10) $display("FAIL sb_valid: got mv/em=%b, required 10", {mem_valid, empty});
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_data, mem_be} !== {32'h0000_1000, 32'hA5A5_A5A5, 4'b1000})
      $display("FAIL sb_lanes: got addr=%h data=%h be=%b, required 00001000 a5a5a5a5 1000", mem_addr, mem_data, mem_be);
    else n_pass++;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    n_checks++;
    if (empty !== 1'b1) $display("FAIL sb_drained: got empty=%b, required 1", empty);
    else n_pass++;
  endtask

  task automatic test_half_word();
    mem_ready = 1'b1;
    drive_store(3'b001, 32'h0000_2002, 32'h0000_BEEF);
    n_checks++;
    if ({mem_addr, mem_data, mem_be} !== {32'h0000_2000, 32'hBEEF_BEEF, 4'b1100})
      $display("FAIL sh_lanes: got addr=%h data=%h be=%b, required 00002000 beefbeef 1100", mem_addr, mem_data, mem_be);
    else n_pass++;
    drive_store(3'b010, 32'h0000_2004, 32'h1234_5678);
    n_checks++;
    if ({mem_addr, mem_data, mem_be} !== {32'h0000_2004, 32'h1234_5678, 4'b1111})
      $display("FAIL sw_lanes: got addr=%h data=%h be=%b, required 00002004 12345678 1111", mem_addr, mem_data, mem_be);
    else n_pass++;
    wait_empty(10);
    mem_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [2:0]    modes [3];
    logic [AW-1:0] addrs [3];
    modes = '{3'b010, 3'b001, 3'b100};
    addrs = '{32'h0000_3001, 32'h0000_3003, 32'h0000_3000};
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_store(modes[i], addrs[i], 32'hDEAD_0000 + i);
      n_checks++;
      if ({store_err, empty} !== 2'b11)
        $display("FAIL illegal_%0d_pulse: got err/empty=%b, required 11", i, {store_err, empty});
      else n_pass++;
      tick();
      n_checks++;
      if ({store_err, empty} !== 2'b01)
        $display("FAIL illegal_%0d_clear: got err/empty=%b, required 01", i, {store_err, empty});
      else n_pass++;
    end
  endtask

  task automatic test_full_wrap();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_store(3'b010, 32'(i * 4), 32'hA000_0000 + 32'(i * 4));
    n_checks++;
    if ({full, st_ready, mem_addr} !== {2'b10, 32'h0})
      $display("FAIL full_flags: got full/rdy=%b head=%h, required 10 head=0", {full, st_ready}, mem_addr);
    else n_pass++;
    st_valid     = 1'b1;
    st_addr_mode = 3'b010;
    st_addr      = 32'h0000_0010;
    st_data      = 32'hA000_0010;
    tick();
    n_checks++;
    if ({full, st_ready, mem_addr} !== {2'b10, 32'h0})
      $display("FAIL full_hold: got full/rdy=%b head=%h, required 10 head=0", {full, st_ready}, mem_addr);
    else n_pass++;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    n_checks++;
    if ({full, st_ready, mem_addr} !== {2'b01, 32'h4})
      $display("FAIL full_drain1: got full/rdy=%b head=%h, required 01 head=4", {full, st_ready}, mem_addr);
    else n_pass++;
    exp_q.push_back(fmt(3'b010, 32'h0000_0010, 32'hA000_0010));
    tick();
    st_valid = 1'b0;
    n_checks++;
    if ({full, st_ready} !== 2'b10) $display("FAIL full_refill: got full/rdy=%b, required 10", {full, st_ready});
    else n_pass++;
    mem_ready = 1'b1;
    wait_empty(20);
    mem_ready = 1'b0;
  endtask

  task automatic test_ld_conflict();
    mem_ready = 1'b0;
    drive_store(3'b000, 32'h0000_4001, 32'h0000_0077);
    ld_check_en = 1'b1;
    ld_addr = 32'h0000_4003;
    #1;
    n_checks++;
    if (ld_conflict !== 1'b1) $display("FAIL ld_same_word: got %b, required 1", ld_conflict);
    else n_pass++;
    ld_addr = 32'h0000_4004;
    #1;
    n_checks++;
    if (ld_conflict !== 1'b0) $display("FAIL ld_next_word: got %b, required 0", ld_conflict);
    else n_pass++;
    ld_check_en = 1'b0;
    ld_addr = 32'h0000_4003;
    #1;
    n_checks++;
    if (ld_conflict !== 1'b0) $display("FAIL ld_disabled: got %b, required 0", ld_conflict);
    else n_pass++;
    ld_check_en = 1'b1;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (ld_conflict !== 1'b1) $display("FAIL ld_during_deq: got %b, required 1", ld_conflict);
    else n_pass++;
    tick();
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (ld_conflict !== 1'b0) $display("FAIL ld_after_drain: got %b, required 0", ld_conflict);
    else n_pass++;
    ld_check_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    drive_store(3'b010, 32'h0000_5000, 32'h5555_0000);
    drive_store(3'b010, 32'h0000_5004, 32'h5555_0004);
    rst_n        = 1'b0;
    mem_ready    = 1'b1;
    st_valid     = 1'b1;
    st_addr_mode = 3'b010;
    st_addr      = 32'h0000_5001;
    exp_q.delete();
    tick();
    rst_n    = 1'b1;
    st_valid = 1'b0;
    n_checks++;
    if ({empty, mem_valid, store_err, full} !== 4'b1000)
      $display("FAIL reset_mid: got em/mv/se/fu=%b, required 1000", {empty, mem_valid, store_err, full});
    else n_pass++;
    repeat (4) tick();
    n_checks++;
    if ({empty, mem_be} !== {1'b1, 4'b0000})
      $display("FAIL reset_mid_quiet: got empty=%b be=%b, required 1 0000", empty, mem_be);
    else n_pass++;
    mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int            model_cnt;
    logic          v;
    logic          r;
    logic          acc;
    logic          dq;
    logic [2:0]    mode;
    logic [AW-1:0] a;
    model_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      v    = 1'($urandom_range(0, 1));
      r    = 1'($urandom_range(0, 3) == 0);
      mode = 3'($urandom_range(0, 2));
      a    = 32'h0000_6000 + 32'($urandom_range(0, 63) * 4);
      if (mode == 3'b000) a[1:0] = 2'($urandom_range(0, 3));
      if (mode == 3'b001) a[1]   = 1'($urandom_range(0, 1));
      st_valid     = v;
      st_addr_mode = mode;
      st_addr      = a;
      st_data      = $urandom;
      mem_ready    = r;
      n_checks++;
      if (st_ready !== (model_cnt != DEPTH))
        $display("FAIL b2b_st_ready: got %b, required %b (cnt=%0d)", st_ready, model_cnt != DEPTH, model_cnt);
      else n_pass++;
      acc = v && (model_cnt < DEPTH);
      dq  = r && (model_cnt > 0);
      if (acc) exp_q.push_back(fmt(mode, a, st_data));
      tick();
      model_cnt = model_cnt + int'(acc) - int'(dq);
    end
    st_valid  = 1'b0;
    mem_ready = 1'b1;
    wait_empty(20);
    mem_ready = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n        = 1'b0;
    st_valid     = 1'b0;
    st_addr_mode = 3'b000;
    st_addr      = '0;
    st_data      = '0;
    mem_ready    = 1'b0;
    ld_check_en  = 1'b0;
    ld_addr      = '0;
    test_reset();
    test_byte_store();
    test_half_word();
    test_illegal();
    test_full_wrap();
    test_ld_conflict();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Store-side counterpart to the load formatting path in front of the data cache.
- Accepts CPU store requests (SB/SH/SW) and checks alignment.
- Places data on the correct byte lanes with per-byte write enables.
- Queues stores in a small FIFO that drains word-aligned writes into the cache/memory port under a valid/ready handshake.
- Flags pending stores that overlap a load address so the pipeline can stall that load.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; only 32 is supported
- DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- st_valid  input  1  store request present
- st_ready  output  1  buffer can accept; equals !full
- st_addr_mode  input  3  DATA_ADDR_MODE_* from def.sv: B=000, H=001, W=010
- st_addr  input  ADDR_WIDTH  byte address
- st_data  input  DATA_WIDTH  store data, right-justified
- mem_valid  output  1  head entry valid; equals !empty
- mem_ready  input  1  downstream accepts the head entry
- mem_addr  output  ADDR_WIDTH  head word address, bits [1:0]=00
- mem_data  output  DATA_WIDTH  lane-aligned head data
- mem_be  output  4  head byte enables; bit i covers bits [8i+7:8i]
- ld_check_en  input  1  a load is probing this cycle
- ld_addr  input  ADDR_WIDTH  load byte address
- ld_conflict  output  1  a pending entry overlaps the load word
- store_err  output  1  registered one-cycle pulse for a misaligned or illegal store
- full  output  1  count==DEPTH
- empty  output  1  count==0

Behaviour:
- Reset state: rst_n=0 sampled at a clk edge clears head, tail, count and store_err.
- Outputs in reset and whenever the FIFO is empty: mem_valid=0, mem_addr=0, mem_data=0, mem_be=0, ld_conflict=0, empty=1, full=0, st_ready=1.
- Reset mid-operation: all pending entries are discarded with no drain.
- Accept: a request is taken when st_valid && st_ready at a clk edge.
- Legality check on an accepted request:
  - Illegal: mode not in {B,H,W}, which includes BU/HU.
  - Misaligned: H with addr[0]=1, or W with addr[1:0]!=0.
  - Either case: the request is consumed and dropped (not enqueued); store_err=1 for the following cycle only.
  - A legal request never raises store_err.
- Lane formatting for legal requests, with off = st_addr[1:0]:
  - B: mem_data = {4{st_data[7:0]}}, be = 4'b0001 << off.
  - H: mem_data = {2{st_data[15:0]}}, be = 4'b0011 (off=00) or 4'b1100 (off=10).
  - W: mem_data = st_data, be = 4'b1111.
  - Stored address = {st_addr[31:2], 2'b00}.
- FIFO mechanics:
  - Entry = {addr, data, be, valid}; circular head/tail pointers of log2(DEPTH) bits wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - Head entry drives mem_* directly from storage; no added latency. An enqueue into an empty FIFO appears on mem_* the next cycle.
- Dequeue: occurs when mem_valid && mem_ready at a clk edge; head advances and the entry valid bit clears.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
  - When full, st_ready=0, so no enqueue occurs even if a dequeue happens in that cycle. There is no same-cycle bypass.
- Ordering: strict FIFO; entries are never coalesced or reordered.
- mem_valid stays high and mem_* stays stable until mem_ready. Downstream may hold mem_ready low indefinitely.
- ld_conflict is combinational:
  - Asserted when ld_check_en && any valid entry has addr[31:2] == ld_addr[31:2].
  - Covers entries only; a store being accepted in the same cycle is not checked.
  - An entry dequeued this cycle still counts as a conflict during this cycle.
- full/empty are combinational from count.

Test Plan:
1. Reset, then SB addr=0x1003 data=0x000000A5, mem_ready=0 -> next cycle mem_valid=1, mem_addr=0x1000, mem_be=4'b1000, mem_data=0xA5A5A5A5, empty=0.
2. SH addr=0x2002 data=0x0000BEEF, then SW addr=0x2004 data=0x12345678 with mem_ready=1 -> two ordered transfers: (0x2000, 0xBEEFBEEF, 1100) then (0x2004, 0x12345678, 1111); FIFO returns to empty.
3. SW addr=0x3001 and SH addr=0x3003 -> each raises store_err for exactly one cycle, nothing is enqueued, empty stays 1; mode 3'b100 (BU) behaves the same.
4. With mem_ready=0, issue 5 legal SWs to addresses 0x0, 0x4, 0x8, 0xC, 0x10 -> after 4 accepts full=1, st_ready=0 and the fifth is held. Raise mem_ready for one cycle -> 0x0 drains, next cycle the fifth is accepted; pointers wrap and subsequent drain order is 0x4, 0x8, 0xC, 0x10.
5. Pending SB addr=0x4001, then ld_check_en=1 with ld_addr=0x4003 -> ld_conflict=1; ld_addr=0x4004 -> 0; after the entry drains, ld_addr=0x4003 -> 0.
6. Fill 2 entries, assert rst_n=0 for one cycle while mem_ready=1 -> next cycle empty=1, mem_valid=0, store_err=0; no further mem transfers occur.
